mmio_joypad_m: RTL
==================

// Module: mmio_joypad_m
// PURPOSE
//  Joypad MMIO unit at 0xFF00 (P1/JOYP); drives interrupts.joypad (IF bit 4), which is currently tied low.
//  Synchronises and debounces 8 raw board buttons, then presents them through the P1 select/read matrix.
//  Raises a 1-cycle joypad interrupt pulse on any high->low transition of P1[3:0].
//  Sits beside mmio_timer_m / mmio_apu_m: the MMU decodes 0xFF00 into req_sel.
// PARAMETERS
//  DEBOUNCE_CYCLES  16384  clk cycles an input must be stable before acceptance (~3.9 ms at 4.16 MHz)
//  CNT_W            15     debounce counter width; must satisfy 2**CNT_W >= DEBOUNCE_CYCLES
// PORTS
//  clk          in   1  system clock (clk_4mhz domain)
//  rst          in   1  synchronous, active-high reset
//  btn_raw      in   8  async board buttons, 1=pressed: [7]start [6]select [5]b [4]a [3]down [2]up [1]left [0]right
//  req_sel      in   1  MMU decode hit on 0xFF00 this cycle
//  req_we       in   1  1=write, 0=read (valid with req_sel)
//  req_wdata    in   8  write data
//  req_rdata    out  8  read data, registered; valid 1 cycle after a read
//  int_joypad   out  1  1-cycle interrupt request pulse to mmio_interrupts_m
//  btn_state    out  8  debounced button state, 1=pressed (LEDs/debug)
// BEHAVIOUR
//  Reset (rst=1 at posedge): sync flops=0, stable=8'h00, all counters=0, p1_sel[1:0]=2'b11,
//   nib_q=4'hF, req_rdata=8'hFF, int_joypad=0, btn_state=0. Reset mid-debounce discards progress.
//  Sync: 2-flop synchroniser per bit -> s[7:0].
//  Debounce, per bit i:
//   - s[i]==stable[i]: cnt[i]<=0.
//   - else, cnt[i]==DEBOUNCE_CYCLES-1: stable[i]<=s[i], cnt[i]<=0.
//   - else: cnt[i]<=cnt[i]+1.
//   - Any bounce back to stable[i] restarts from 0.
//   - Acceptance latency from a clean btn_raw edge = 2 + DEBOUNCE_CYCLES cycles.
//   - btn_state = stable.
//  P1 select: on req_sel&req_we, p1_sel <= req_wdata[5:4]; other bits ignored.
//   bit5 = P15 (0 selects action), bit4 = P14 (0 selects direction).
//  Nibble (comb, active-low):
//   nib[n] = ~((~p1_sel[0] & stable[n]) | (~p1_sel[1] & stable[n+4])), n=0..3.
//   Both groups selected -> OR of presses; neither selected -> 4'hF.
//  Read: on req_sel&~req_we, req_rdata <= {2'b11, p1_sel, nib} at that posedge; otherwise holds.
//   Read issued in the same cycle as a write returns the pre-write p1_sel.
//  Interrupt:
//   - nib_q <= nib every cycle.
//   - int_joypad <= |(nib_q & ~nib) (registered, exactly 1 cycle).
//   - Fires both for presses and for select writes that expose a held key.
//   - Rising bits (releases) never fire.
//   - Multiple bits falling together -> one pulse.
//   - A continuously held key does not re-fire.
//  Writes to 0xFF00 never alter stable or cnt.
//  req_sel with no access is a no-op.
// TESTING
//  Use DEBOUNCE_CYCLES=8 in the bench.
//  1 Reset: rst high 2 cycles, then read 0xFF00 -> rdata=8'hFF; int_joypad=0; btn_state=0.
//  2 Debounce: btn_raw[0]=1 steady; btn_state[0] rises exactly 10 cycles later.
//    A 5-cycle glitch on btn_raw[4] never reaches btn_state.
//  3 Matrix: write 8'h20 (direction), hold right+up -> read 8'hEA.
//    Write 8'h10, hold a+start -> read 8'hD6.
//    Write 8'h30 -> read 8'hFF.
//  4 Interrupt: sel=direction, press down -> exactly one int_joypad pulse 1 cycle after nibble bit3 falls.
//    Release -> no pulse. Held key -> no further pulses.
//  5 Select-exposure: hold b with sel=2'b11, write 8'h10 -> one int_joypad pulse; read = 8'hDD.
//  6 Reset mid-debounce: raw press, assert rst at cycle 5 -> btn_state stays 0.
//    After rst drops with the button still held, the full 2+8 cycles are needed again.

Source files
------------

// File: rtl/mmio_joypad_m_if.sv
// Register bus for the P1/JOYP MMIO slot at 0xFF00.
// The MMU drives the request side; the joypad unit returns registered read data.
interface mmio_joypad_m_if;
    logic       req_sel;    // MMU decode hit on 0xFF00 this cycle
    logic       req_we;     // 1=write, 0=read (valid with req_sel)
    logic [7:0] req_wdata;  // write data
    logic [7:0] req_rdata;  // read data, valid 1 cycle after a read

    modport master (
        output req_sel,
        output req_we,
        output req_wdata,
        input  req_rdata
    );

    modport slave (
        input  req_sel,
        input  req_we,
        input  req_wdata,
        output req_rdata
    );
endinterface

// File: rtl/mmio_joypad_m.sv
// Joypad MMIO unit (P1/JOYP at 0xFF00).
// Synchronises and debounces eight raw board buttons, presents them through
// the active-low P1 select/read matrix, and raises a one-cycle interrupt on
// any high->low transition of the visible nibble.
module mmio_joypad_m #(
    parameter int DEBOUNCE_CYCLES = 16384,
    parameter int CNT_W           = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [7:0]           i_btn_raw,   // [7]start [6]select [5]b [4]a [3]down [2]up [1]left [0]right
    mmio_joypad_m_if.slave       bus,
    output logic                 o_int_joypad,
    output logic [7:0]           o_btn_state
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [7:0]       r_sync1;
    logic [7:0]       r_sync2;
    logic [7:0]       r_stable;
    logic [CNT_W-1:0] r_cnt [8];
    logic [1:0]       r_p1_sel;    // [1]=P15 (0 selects action), [0]=P14 (0 selects direction)
    logic [3:0]       r_nib_q;
    logic [7:0]       r_rdata;
    logic             r_int;

    logic [3:0]       w_nib;
    logic             w_wr;
    logic             w_rd;

    assign w_wr = bus.req_sel &  bus.req_we;
    assign w_rd = bus.req_sel & ~bus.req_we;

    // Two-flop synchroniser for the asynchronous board buttons.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= i_btn_raw;
            r_sync2 <= r_sync1;
        end
    end

    // Per-bit debounce: a new level is accepted only after DEBOUNCE_CYCLES stable cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stable <= '0;
            // NOTE: the counter array is reset explicitly so a reset mid-debounce discards progress.
            for (int i = 0; i < 8; i++) r_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (r_sync2[i] == r_stable[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == CNT_LAST) begin
                    r_stable[i] <= r_sync2[i];
                    r_cnt[i]    <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
            end
        end
    end

    // P1 select bits: only bits [5:4] of a write are kept.
    always_ff @(posedge clk) begin
        if (rst) r_p1_sel <= 2'b11;
        else if (w_wr) r_p1_sel <= bus.req_wdata[5:4];
    end

    // Active-low matrix: a selected group pulls the nibble bit low for each press.
    // NOTE: continuous assignment covers every bit unconditionally, so no latch can form.
    assign w_nib = ~(({4{~r_p1_sel[0]}} & r_stable[3:0]) |
                     ({4{~r_p1_sel[1]}} & r_stable[7:4]));

    // Registered read port; a read in the same cycle as a write sees the old select.
    always_ff @(posedge clk) begin
        if (rst) r_rdata <= 8'hFF;
        else if (w_rd) r_rdata <= {2'b11, r_p1_sel, w_nib};
    end

    // Falling-edge detect on the visible nibble, one pulse per transition event.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_nib_q <= 4'hF;
            r_int   <= 1'b0;
        end else begin
            r_nib_q <= w_nib;
            r_int   <= |(r_nib_q & ~w_nib);
        end
    end

    assign bus.req_rdata = r_rdata;
    assign o_int_joypad  = r_int;
    assign o_btn_state   = r_stable;

endmodule
